// File: rtl/pipe_pkg.sv
// Shared pipeline types for the hazard/forwarding controller.
//   fwd_sel_e  : ALU operand source select (regfile / M / W)
//   hz_state_e : controller FSM states
//   sb_entry_t : shadow scoreboard entry {rd, reg_wr, mem_rd}
package pipe_pkg;

  localparam int unsigned PIPE_REG_AW = 5;

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_M  = 2'b01,
    FWD_W  = 2'b10
  } fwd_sel_e;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } hz_state_e;

  typedef struct packed {
    logic [PIPE_REG_AW-1:0] rd;
    logic                   reg_wr;
    logic                   mem_rd;
  } sb_entry_t;

  // A producer matches a reader only on a non-x0 register index.
  function automatic logic rd_match(input logic [PIPE_REG_AW-1:0] rd,
                                    input logic [PIPE_REG_AW-1:0] rs);
    return (rd != '0) && (rd == rs);
  endfunction

endpackage

// File: rtl/hazard_fwd_mux_sel.sv
// Forwarding source select for one ALU operand.
//   i_m_rd/i_m_wr : destination and write-enable of the instruction in M
//   i_w_rd/i_w_wr : destination and write-enable of the instruction in W
//   i_rs          : source register read by the instruction in E
//   o_sel         : FWD_M if M produces i_rs, else FWD_W if W does, else FWD_RF
module hazard_fwd_mux_sel
  import pipe_pkg::*;
(
  input  logic [PIPE_REG_AW-1:0] i_m_rd,
  input  logic                   i_m_wr,
  input  logic [PIPE_REG_AW-1:0] i_w_rd,
  input  logic                   i_w_wr,
  input  logic [PIPE_REG_AW-1:0] i_rs,
  output fwd_sel_e               o_sel
);

  // M is younger than W, so its value wins when both write the same register.
  always_comb begin
    o_sel = FWD_RF;
    if (i_m_wr && rd_match(i_m_rd, i_rs)) begin
      o_sel = FWD_M;
    end else if (i_w_wr && rd_match(i_w_rd, i_rs)) begin
      o_sel = FWD_W;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard and forwarding controller for the 5-stage RV32 pipeline.
// Keeps a shadow scoreboard of E/M/W destinations and produces the
// stall/flush controls for every pipe register plus ALU forwarding selects.
// Optional feature macro: HAZARD_PERF_EN (adds saturating perf counters).
// Ports:
//   clk, reset                 : clock, asynchronous active-high reset
//   valid_D, rs1_D, rs2_D, rd_D,
//   reg_wr_D, mem_rd_D         : instruction currently in decode
//   rs1_E, rs2_E               : sources of the instruction in execute
//   br_taken_E                 : taken branch/jump resolved in E
//   dmem_busy                  : data memory not ready, freeze whole pipe
//   stall_F/D/E/M, flush_D/E   : pipe register controls (combinational)
//   fwd_a_E, fwd_b_E           : ALU operand source selects (combinational)
//   perf_lu_cnt, perf_flush_cnt,
//   perf_wait_cnt              : load-use / redirect / busy cycle counts
module hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int unsigned REG_AW = 5
`ifdef HAZARD_PERF_EN
  ,
  parameter int unsigned PERF_W = 32
`endif
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid_D,
  input  logic [REG_AW-1:0] rs1_D,
  input  logic [REG_AW-1:0] rs2_D,
  input  logic [REG_AW-1:0] rd_D,
  input  logic              reg_wr_D,
  input  logic              mem_rd_D,
  input  logic [REG_AW-1:0] rs1_E,
  input  logic [REG_AW-1:0] rs2_E,
  input  logic              br_taken_E,
  input  logic              dmem_busy,
  output logic              stall_F,
  output logic              stall_D,
  output logic              stall_E,
  output logic              stall_M,
  output logic              flush_D,
  output logic              flush_E,
  output logic [1:0]        fwd_a_E,
  output logic [1:0]        fwd_b_E
`ifdef HAZARD_PERF_EN
  ,
  output logic [PERF_W-1:0] perf_lu_cnt,
  output logic [PERF_W-1:0] perf_flush_cnt,
  output logic [PERF_W-1:0] perf_wait_cnt
`endif
);

  hz_state_e r_state;
  hz_state_e w_state_nxt;
  logic      r_redirect_pend;
  sb_entry_t r_sb_e;
  sb_entry_t r_sb_m;
  sb_entry_t r_sb_w;
  sb_entry_t w_sb_dec;
  logic      w_lu;
  logic      w_lu_stall;
  logic      w_redirect;
  fwd_sel_e  w_fwd_a;
  fwd_sel_e  w_fwd_b;
  logic      w_unused_w_mem_rd;

  // W-stage load flag is kept for a complete entry but nothing consumes it.
  assign w_unused_w_mem_rd = r_sb_w.mem_rd;

  // Decode fields entering E; a bubble or invalid slot carries no write/load.
  always_comb begin
    w_sb_dec.rd     = PIPE_REG_AW'(rd_D);
    w_sb_dec.reg_wr = reg_wr_D & valid_D & ~flush_E;
    w_sb_dec.mem_rd = mem_rd_D & valid_D & ~flush_E;
  end

  // Load in E feeding the instruction in decode.
  assign w_lu = valid_D && r_sb_e.mem_rd &&
                (rd_match(r_sb_e.rd, PIPE_REG_AW'(rs1_D)) ||
                 rd_match(r_sb_e.rd, PIPE_REG_AW'(rs2_D)));

  // Next state and pipe controls; freeze > redirect > load-use > normal.
  // Reset forces all controls low without waiting for a clock edge.
  always_comb begin
    w_state_nxt = r_state;
    stall_F     = 1'b0;
    stall_D     = 1'b0;
    stall_E     = 1'b0;
    stall_M     = 1'b0;
    flush_D     = 1'b0;
    flush_E     = 1'b0;
    w_lu_stall  = 1'b0;
    w_redirect  = 1'b0;

    case (r_state)
      RUN:      if (dmem_busy)  w_state_nxt = MEM_WAIT;
      MEM_WAIT: if (!dmem_busy) w_state_nxt = RUN;
      default:  w_state_nxt = RUN;
    endcase

    if (!reset) begin
      if (dmem_busy) begin
        stall_F = 1'b1;
        stall_D = 1'b1;
        stall_E = 1'b1;
        stall_M = 1'b1;
      end else if (br_taken_E || r_redirect_pend) begin
        // The dependent instruction is squashed, so load-use needs no stall.
        flush_D    = 1'b1;
        flush_E    = 1'b1;
        w_redirect = 1'b1;
      end else if (w_lu) begin
        stall_F    = 1'b1;
        stall_D    = 1'b1;
        flush_E    = 1'b1;
        w_lu_stall = 1'b1;
      end
    end
  end

  // FSM, pending redirect and shadow scoreboard.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state         <= RUN;
      r_redirect_pend <= 1'b0;
      r_sb_e          <= '0;
      r_sb_m          <= '0;
      r_sb_w          <= '0;
    end else begin
      r_state         <= w_state_nxt;
      // A branch seen during a freeze is replayed on the first free cycle.
      r_redirect_pend <= dmem_busy & (r_redirect_pend | br_taken_E);
      if (!stall_M) begin
        r_sb_e <= w_sb_dec;
        r_sb_m <= r_sb_e;
        r_sb_w <= r_sb_m;
      end
    end
  end

  hazard_fwd_mux_sel u_fwd_a (
    .i_m_rd (r_sb_m.rd),
    .i_m_wr (r_sb_m.reg_wr),
    .i_w_rd (r_sb_w.rd),
    .i_w_wr (r_sb_w.reg_wr),
    .i_rs   (PIPE_REG_AW'(rs1_E)),
    .o_sel  (w_fwd_a)
  );

  hazard_fwd_mux_sel u_fwd_b (
    .i_m_rd (r_sb_m.rd),
    .i_m_wr (r_sb_m.reg_wr),
    .i_w_rd (r_sb_w.rd),
    .i_w_wr (r_sb_w.reg_wr),
    .i_rs   (PIPE_REG_AW'(rs2_E)),
    .o_sel  (w_fwd_b)
  );

  assign fwd_a_E = w_fwd_a;
  assign fwd_b_E = w_fwd_b;

`ifdef HAZARD_PERF_EN
  // Saturating event counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_lu_cnt    <= '0;
      perf_flush_cnt <= '0;
      perf_wait_cnt  <= '0;
    end else begin
      if (w_lu_stall && (perf_lu_cnt != '1)) begin
        perf_lu_cnt <= perf_lu_cnt + PERF_W'(1);
      end
      if (w_redirect && (perf_flush_cnt != '1)) begin
        perf_flush_cnt <= perf_flush_cnt + PERF_W'(1);
      end
      if (dmem_busy && (perf_wait_cnt != '1)) begin
        perf_wait_cnt <= perf_wait_cnt + PERF_W'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl.
// Inputs change 1 time unit after the rising edge; outputs are sampled
// 1 time unit later, well clear of the next edge.
module tb_hazard_ctrl;

  logic       clk;
  logic       reset;
  logic       valid_D;
  logic [4:0] rs1_D, rs2_D, rd_D;
  logic       reg_wr_D, mem_rd_D;
  logic [4:0] rs1_E, rs2_E;
  logic       br_taken_E;
  logic       dmem_busy;
  logic       stall_F, stall_D, stall_E, stall_M, flush_D, flush_E;
  logic [1:0] fwd_a_E, fwd_b_E;
`ifdef HAZARD_PERF_EN
  logic [31:0] perf_lu_cnt, perf_flush_cnt, perf_wait_cnt;
`endif
  logic [5:0] ctl;

  int n_checks = 0;
  int n_errors = 0;

  hazard_ctrl dut (
    .clk            (clk),
    .reset          (reset),
    .valid_D        (valid_D),
    .rs1_D          (rs1_D),
    .rs2_D          (rs2_D),
    .rd_D           (rd_D),
    .reg_wr_D       (reg_wr_D),
    .mem_rd_D       (mem_rd_D),
    .rs1_E          (rs1_E),
    .rs2_E          (rs2_E),
    .br_taken_E     (br_taken_E),
    .dmem_busy      (dmem_busy),
    .stall_F        (stall_F),
    .stall_D        (stall_D),
    .stall_E        (stall_E),
    .stall_M        (stall_M),
    .flush_D        (flush_D),
    .flush_E        (flush_E),
`ifdef HAZARD_PERF_EN
    .perf_lu_cnt    (perf_lu_cnt),
    .perf_flush_cnt (perf_flush_cnt),
    .perf_wait_cnt  (perf_wait_cnt),
`endif
    .fwd_a_E        (fwd_a_E),
    .fwd_b_E        (fwd_b_E)
  );

  // {stall_F, stall_D, stall_E, stall_M, flush_D, flush_E}
  assign ctl = {stall_F, stall_D, stall_E, stall_M, flush_D, flush_E};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic dec(input logic v, input logic [4:0] r1, input logic [4:0] r2,
                     input logic [4:0] rd, input logic wr, input logic mr);
    valid_D  = v;
    rs1_D    = r1;
    rs2_D    = r2;
    rd_D     = rd;
    reg_wr_D = wr;
    mem_rd_D = mr;
  endtask

  task automatic ex(input logic [4:0] r1, input logic [4:0] r2);
    rs1_E = r1;
    rs2_E = r2;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    dec(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    ex(5'd0, 5'd0);
    br_taken_E = 1'b0;
    dmem_busy  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ctl", 32'(ctl), 32'h0);
    chk("rst_fwd", 32'({fwd_a_E, fwd_b_E}), 32'h0);
    reset = 1'b0;

    // lw x5 ; add x6,x5,x1
    dec(1'b1, 5'd1, 5'd2, 5'd5, 1'b1, 1'b1); #1;
    chk("lw_issue_ctl", 32'(ctl), 32'h0);
    tick();
    dec(1'b1, 5'd5, 5'd1, 5'd6, 1'b1, 1'b0); #1;
    chk("lu_bubble_ctl", 32'(ctl), 32'(6'b110001));
    tick();
    #1;
    chk("lu_release_ctl", 32'(ctl), 32'h0);
    tick();
    dec(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    ex(5'd5, 5'd1); #1;
    chk("lu_fwd_a_w", 32'(fwd_a_E), 32'(2'b10));
    chk("lu_fwd_b_rf", 32'(fwd_b_E), 32'(2'b00));
    tick();

    // add x3,x1,x2 ; sub x4,x3,x3
    ex(5'd0, 5'd0);
    dec(1'b1, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0);
    tick();
    dec(1'b1, 5'd3, 5'd3, 5'd4, 1'b1, 1'b0);
    ex(5'd1, 5'd2); #1;
    chk("alu_dep_ctl", 32'(ctl), 32'h0);
    chk("add_fwd_none", 32'({fwd_a_E, fwd_b_E}), 32'h0);
    tick();
    dec(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    ex(5'd3, 5'd3); #1;
    chk("sub_fwd_m", 32'({fwd_a_E, fwd_b_E}), 32'(4'b0101));
    tick();
    ex(5'd3, 5'd4); #1;
    chk("mixed_fwd_w_m", 32'({fwd_a_E, fwd_b_E}), 32'(4'b1001));
    tick();

    // Two back-to-back writers of x7: M must win over W
    dec(1'b1, 5'd0, 5'd0, 5'd7, 1'b1, 1'b0);
    tick();
    tick();
    dec(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    tick();
    ex(5'd7, 5'd7); #1;
    chk("m_over_w", 32'({fwd_a_E, fwd_b_E}), 32'(4'b0101));

    // lw x0 ; reader of x0
    ex(5'd0, 5'd0);
    dec(1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1);
    tick();
    dec(1'b1, 5'd0, 5'd0, 5'd8, 1'b1, 1'b0); #1;
    chk("x0_no_lu", 32'(ctl), 32'h0);
    tick();
    dec(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    ex(5'd0, 5'd0); #1;
    chk("x0_no_fwd", 32'({fwd_a_E, fwd_b_E}), 32'h0);
    repeat (3) tick();

    // Branch resolves in the same cycle as a load-use
    dec(1'b1, 5'd0, 5'd0, 5'd9, 1'b1, 1'b1);
    tick();
    dec(1'b1, 5'd9, 5'd0, 5'd10, 1'b1, 1'b0);
    br_taken_E = 1'b1; #1;
    chk("br_over_lu", 32'(ctl), 32'(6'b000011));
    tick();
    br_taken_E = 1'b0;
    dec(1'b1, 5'd1, 5'd2, 5'd11, 1'b1, 1'b0); #1;
    chk("br_no_extra_bubble", 32'(ctl), 32'h0);
    tick();

    // Busy for 3 cycles with a branch on the first; x12 writer sits in E
    dec(1'b1, 5'd1, 5'd2, 5'd12, 1'b1, 1'b0);
    tick();
    dec(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    dmem_busy  = 1'b1;
    br_taken_E = 1'b1; #1;
    chk("busy_c1", 32'(ctl), 32'(6'b111100));
    tick();
    br_taken_E = 1'b0; #1;
    chk("busy_c2", 32'(ctl), 32'(6'b111100));
    tick();
    chk("busy_c3", 32'(ctl), 32'(6'b111100));
    tick();
    dmem_busy = 1'b0; #1;
    chk("busy_drop_redirect", 32'(ctl), 32'(6'b000011));
    tick();
    ex(5'd12, 5'd11); #1;
    chk("post_redirect_ctl", 32'(ctl), 32'h0);
    chk("freeze_held_sb", 32'({fwd_a_E, fwd_b_E}), 32'(4'b0110));

    // Fresh reset, two load-use events, five busy cycles
    ex(5'd0, 5'd0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int k = 0; k < 2; k++) begin
      dec(1'b1, 5'd0, 5'd0, 5'd5, 1'b1, 1'b1);
      tick();
      dec(1'b1, 5'd5, 5'd0, 5'd6, 1'b1, 1'b0); #1;
      chk("lu_event_ctl", 32'(ctl), 32'(6'b110001));
      tick();
      dec(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
      tick();
    end
    dmem_busy = 1'b1;
    repeat (5) tick();
    dmem_busy = 1'b0; #1;
`ifdef HAZARD_PERF_EN
    chk("perf_lu", perf_lu_cnt, 32'd2);
    chk("perf_wait", perf_wait_cnt, 32'd5);
    chk("perf_flush", perf_flush_cnt, 32'd0);
`endif

    // Reset asserted in the middle of a freeze with a redirect pending
    dmem_busy  = 1'b1;
    br_taken_E = 1'b1;
    tick();
    #2;
    reset = 1'b1; #1;
    chk("rst_mid_busy_ctl", 32'(ctl), 32'h0);
`ifdef HAZARD_PERF_EN
    chk("rst_perf_lu", perf_lu_cnt, 32'd0);
    chk("rst_perf_wait", perf_wait_cnt, 32'd0);
    chk("rst_perf_flush", perf_flush_cnt, 32'd0);
`endif
    dmem_busy  = 1'b0;
    br_taken_E = 1'b0;
    #1;
    reset = 1'b0; #1;
    chk("rst_pend_dropped", 32'(ctl), 32'h0);
    tick();
    chk("rst_run_idle", 32'(ctl), 32'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
